fc_seq_ctrl: RTL and testbench
==============================

// Module: fc_seq_ctrl
// PURPOSE
//  Sequencer for the FC classifier path (flatten -> fc_accum -> cmp7seg).
//  On start, streams INPUT_NUM int8 features from the feature buffer into the FC path.
//  It then waits for the classification result, latches is_one and reports done or err.
//  Sits between the feature buffer and fc_top; owns the buffer read port while busy.
// PARAMETERS
//  INPUT_NUM  3136   features per frame (14*14*16)
//  DATA_BITS  8      feature width, signed
//  ADDR_BITS  12     buffer address width; must satisfy 2**ADDR_BITS >= INPUT_NUM
//  TIMEOUT    64     max cycles waited in DRAIN for sum_valid
// PORTS
//  clk            in   1          clock, rising edge
//  rst            in   1          synchronous reset, active-high
//  start          in   1          request a frame; accepted only in IDLE
//  abort          in   1          cancel the current frame
//  stall          in   1          pause buffer reads this cycle (shared BRAM port)
//  buf_rd_en      out  1          buffer read enable
//  buf_addr       out  ADDR_BITS  buffer read address
//  buf_rd_data    in   DATA_BITS  buffer data, valid 1 cycle after buf_rd_en
//  feat_valid     out  1          feature strobe to fc_top
//  feat_data      out  DATA_BITS  feature to fc_top (signed)
//  sum_valid      in   1          result-valid from fc_top
//  is_one         in   1          class result from fc_top
//  busy           out  1          1 in STREAM/DRAIN
//  done           out  1          1-cycle pulse at frame end (success or timeout)
//  err            out  1          sticky timeout flag; cleared on the next accepted start
//  result_is_one  out  1          latched is_one of the last good frame
//  frame_cnt      out  16         count of good frames; wraps 0xFFFF->0
//  fc_clr         out  1          1-cycle pulse to reset the FC path (top ORs it into the fc reset)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; buf_addr=0; read counter cleared.
//  States IDLE, STREAM, DRAIN, DONE; all transitions registered.
//  IDLE:
//   - start & !abort -> STREAM; clears err; buf_addr=0.
//   - start while not IDLE is ignored.
//  STREAM:
//   - !stall -> buf_rd_en=1; issue buf_addr, then buf_addr+1 the next cycle.
//   - stall -> buf_rd_en=0; address holds.
//   - After issuing INPUT_NUM-1 unstalled -> DRAIN.
//   - Exactly INPUT_NUM reads are issued per frame.
//  Feature path:
//   - feat_valid = buf_rd_en delayed 1 cycle.
//   - feat_data = buf_rd_data, passed combinationally (no extra register).
//   - The last feat_valid occurs in the first DRAIN cycle.
//  DRAIN:
//   - Timeout counter starts at 0 on entry.
//   - sum_valid -> result_is_one<=is_one, frame_cnt++, go DONE.
//   - Counter reaches TIMEOUT-1 without sum_valid -> err<=1, fc_clr pulse, go DONE.
//   - result_is_one and frame_cnt are left unchanged on timeout.
//   - sum_valid and timeout in the same cycle: sum_valid wins.
//  DONE: done=1 for one cycle -> IDLE. busy=0 in DONE.
//  Abort:
//   - In STREAM/DRAIN/DONE: next cycle IDLE and fc_clr=1 for one cycle.
//   - No done pulse; buf_rd_en=0 immediately (registered).
//   - Pending feat_valid from a read already issued is suppressed.
//   - Abort in IDLE has no effect; abort beats start in the same cycle.
//  sum_valid outside DRAIN is ignored.
//  rst mid-frame: immediate return to reset values; no done and no fc_clr pulse.
//   The top also holds the FC path in reset during rst.
// TESTING (bench overrides INPUT_NUM=8, TIMEOUT=16)
//  1) Buffer holds 1..8; start pulse; no stall.
//     -> buf_addr 0..7 on 8 consecutive cycles.
//     -> feat_data 1..8 with feat_valid one cycle later.
//     -> sum_valid+is_one=1 after 3 cycles: done pulse, result_is_one=1, frame_cnt=1.
//  2) Same frame with stall high for cycles 2-4.
//     -> exactly 8 reads, no duplicate or skipped address, 8 feat_valid strobes.
//  3) Never assert sum_valid.
//     -> 16 DRAIN cycles, then err=1, fc_clr and done pulse.
//     -> frame_cnt unchanged; next start clears err.
//  4) Abort at 4th read.
//     -> next cycle IDLE, busy=0, fc_clr=1, no done, no further feat_valid.
//     -> start+abort in the same IDLE cycle stays IDLE.
//  5) start pulses during STREAM and DRAIN are ignored.
//     sum_valid injected in STREAM is ignored, and 8 reads still occur.
//  6) Preload frame_cnt=0xFFFF via 65535 frames (or force).
//     -> one good frame wraps it to 0; rst mid-STREAM -> all outputs 0 next cycle.

Source files
------------

// File: rtl/fc_seq_ctrl.sv
// fc_seq_ctrl: frame sequencer for the FC classifier path.
// On an accepted start it streams INPUT_NUM features from the feature buffer
// into fc_top. It then waits up to TIMEOUT cycles for the classification
// result, latches is_one, and reports done, or reports err on timeout.
// It owns the buffer read port while busy.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   start, abort      frame request (accepted only when idle) / cancel
//   stall             pause buffer reads this cycle (shared BRAM port)
//   buf_rd_en         buffer read enable
//   buf_addr          buffer read address
//   buf_rd_data       buffer data, valid one cycle after buf_rd_en
//   feat_valid        feature strobe to fc_top
//   feat_data         feature to fc_top (signed)
//   sum_valid         result-valid from fc_top
//   is_one            class result from fc_top
//   busy              high while streaming or draining
//   done              one-cycle pulse at frame end (good frame or timeout)
//   err               sticky timeout flag, cleared by the next accepted start
//   result_is_one     is_one latched from the last good frame
//   frame_cnt         good-frame counter, wraps from 0xFFFF to 0
//   fc_clr            one-cycle pulse that resets the FC path
module fc_seq_ctrl #(
    parameter int INPUT_NUM = 3136,
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 12,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 stall,
    output logic                 buf_rd_en,
    output logic [ADDR_BITS-1:0] buf_addr,
    input  logic [DATA_BITS-1:0] buf_rd_data,
    output logic                 feat_valid,
    output logic [DATA_BITS-1:0] feat_data,
    input  logic                 sum_valid,
    input  logic                 is_one,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 result_is_one,
    output logic [15:0]          frame_cnt,
    output logic                 fc_clr
);

    localparam int TMO_BITS = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(INPUT_NUM - 1);
    localparam logic [TMO_BITS-1:0]  TMO_LAST  = TMO_BITS'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [TMO_BITS-1:0] tmo_cnt;
    logic                accept;
    logic                abort_hit;
    logic                sum_hit;
    logic                tmo_hit;
    logic                rd_last;

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        abort_hit = 1'b0;
        sum_hit   = 1'b0;
        tmo_hit   = 1'b0;
        rd_last   = 1'b0;
        buf_rd_en = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    accept   = 1'b1;
                    state_nx = S_STREAM;
                end
            end
            S_STREAM: begin
                buf_rd_en = !stall;
                // The read of the last address is the final one of the frame.
                if (!stall && buf_addr == LAST_ADDR) begin
                    rd_last  = 1'b1;
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // A result arriving on the timeout cycle still counts as good.
                if (sum_valid) begin
                    sum_hit  = 1'b1;
                    state_nx = S_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit  = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        // Abort overrides every other outcome of an active frame.
        if (abort && state != S_IDLE) begin
            abort_hit = 1'b1;
            sum_hit   = 1'b0;
            tmo_hit   = 1'b0;
            state_nx  = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_addr      <= '0;
            feat_valid    <= 1'b0;
            tmo_cnt       <= '0;
            err           <= 1'b0;
            result_is_one <= 1'b0;
            frame_cnt     <= '0;
            fc_clr        <= 1'b0;
        end else begin
            fc_clr     <= abort_hit | tmo_hit;
            // A read issued in the abort cycle never reaches fc_top.
            feat_valid <= buf_rd_en & ~abort_hit;

            if (accept) begin
                buf_addr <= '0;
            end else if (buf_rd_en && !rd_last) begin
                buf_addr <= buf_addr + 1'b1;
            end

            if (rd_last) begin
                tmo_cnt <= '0;
            end else if (state == S_DRAIN) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (accept) begin
                err <= 1'b0;
            end else if (tmo_hit) begin
                err <= 1'b1;
            end

            if (sum_hit) begin
                result_is_one <= is_one;
                frame_cnt     <= frame_cnt + 16'd1;
            end
        end
    end

    // Buffer data is forwarded without a register; it is gated to zero
    // whenever there is no feature strobe.
    assign feat_data = feat_valid ? buf_rd_data : '0;
    assign busy      = (state == S_STREAM) || (state == S_DRAIN);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Directed bench for fc_seq_ctrl with INPUT_NUM=8 and TIMEOUT=16.
// The feature buffer model returns address+1, so a frame carries features 1..8.
module tb_fc_seq_ctrl;

    localparam int INPUT_NUM = 8;
    localparam int DATA_BITS = 8;
    localparam int ADDR_BITS = 3;
    localparam int TIMEOUT   = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 abort;
    logic                 stall;
    logic                 buf_rd_en;
    logic [ADDR_BITS-1:0] buf_addr;
    logic [DATA_BITS-1:0] buf_rd_data;
    logic                 feat_valid;
    logic [DATA_BITS-1:0] feat_data;
    logic                 sum_valid;
    logic                 is_one;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic                 result_is_one;
    logic [15:0]          frame_cnt;
    logic                 fc_clr;

    int errors = 0;
    int checks = 0;

    fc_seq_ctrl #(
        .INPUT_NUM(INPUT_NUM),
        .DATA_BITS(DATA_BITS),
        .ADDR_BITS(ADDR_BITS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .stall        (stall),
        .buf_rd_en    (buf_rd_en),
        .buf_addr     (buf_addr),
        .buf_rd_data  (buf_rd_data),
        .feat_valid   (feat_valid),
        .feat_data    (feat_data),
        .sum_valid    (sum_valid),
        .is_one       (is_one),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .result_is_one(result_is_one),
        .frame_cnt    (frame_cnt),
        .fc_clr       (fc_clr)
    );

    always #5 clk = ~clk;

    // Synchronous-read buffer holding 1..8 at addresses 0..7.
    always @(posedge clk) begin
        if (buf_rd_en) begin
            buf_rd_data <= 8'(buf_addr) + 8'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_cnt;
        int fv_cnt;
        int busy_cnt;
        int drain_cnt;

        rst = 1'b1; start = 1'b0; abort = 1'b0; stall = 1'b0;
        sum_valid = 1'b0; is_one = 1'b0; buf_rd_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_rd_en", 32'(buf_rd_en), 0);
        check("rst_addr", 32'(buf_addr), 0);
        check("rst_fv", 32'(feat_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_res", 32'(result_is_one), 0);
        check("rst_cnt", 32'(frame_cnt), 0);
        check("rst_fcclr", 32'(fc_clr), 0);
        @(negedge clk); rst = 1'b0;

        // 1) Plain frame: addresses 0..7 back to back, features 1..8 a cycle later
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) begin
                @(negedge clk); #1;
            end
            check("t1_busy", 32'(busy), 1);
            if (k <= 8) begin
                check("t1_rd_en", 32'(buf_rd_en), 1);
                check("t1_addr", 32'(buf_addr), 32'(k - 1));
            end else begin
                check("t1_rd_en_drain", 32'(buf_rd_en), 0);
            end
            if (k >= 2) begin
                check("t1_fv", 32'(feat_valid), 1);
                check("t1_data", 32'(feat_data), 32'(k - 1));
            end else begin
                check("t1_fv_first", 32'(feat_valid), 0);
            end
        end
        @(negedge clk);
        @(negedge clk); sum_valid = 1'b1; is_one = 1'b1;
        @(negedge clk); sum_valid = 1'b0; is_one = 1'b0; #1;
        check("t1_done", 32'(done), 1);
        check("t1_busy_done", 32'(busy), 0);
        check("t1_res", 32'(result_is_one), 1);
        check("t1_cnt", 32'(frame_cnt), 1);
        check("t1_err", 32'(err), 0);
        @(negedge clk); #1;
        check("t1_done_end", 32'(done), 0);

        // 2) Stall during STREAM cycles 2..4: still exactly 8 ordered reads
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        rd_cnt = 0;
        fv_cnt = 0;
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) @(negedge clk);
            stall = (c >= 2 && c <= 4);
            #1;
            if (buf_rd_en) begin
                check("t2_addr", 32'(buf_addr), 32'(rd_cnt));
                rd_cnt++;
            end
            if (feat_valid) begin
                check("t2_data", 32'(feat_data), 32'(fv_cnt + 1));
                fv_cnt++;
            end
        end
        check("t2_reads", 32'(rd_cnt), 8);
        check("t2_strobes", 32'(fv_cnt), 8);
        @(negedge clk); stall = 1'b0; sum_valid = 1'b1; is_one = 1'b0;
        @(negedge clk); sum_valid = 1'b0; #1;
        check("t2_done", 32'(done), 1);
        check("t2_res", 32'(result_is_one), 0);
        check("t2_cnt", 32'(frame_cnt), 2);

        // 3) No result: 16 DRAIN cycles, then timeout
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        busy_cnt = 0;
        drain_cnt = 0;
        for (int c = 0; c < 60 && busy; c++) begin
            busy_cnt++;
            if (!buf_rd_en) drain_cnt++;
            @(negedge clk); #1;
        end
        check("t3_busy_cycles", 32'(busy_cnt), 24);
        check("t3_drain_cycles", 32'(drain_cnt), 16);
        check("t3_done", 32'(done), 1);
        check("t3_err", 32'(err), 1);
        check("t3_fcclr", 32'(fc_clr), 1);
        check("t3_cnt", 32'(frame_cnt), 2);
        @(negedge clk); #1;
        check("t3_done_end", 32'(done), 0);
        check("t3_fcclr_end", 32'(fc_clr), 0);
        check("t3_err_sticky", 32'(err), 1);

        // 4) Abort on the 4th read
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        check("t4_err_clr", 32'(err), 0);
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) begin
                @(negedge clk); #1;
            end
            check("t4_addr", 32'(buf_addr), 32'(k - 1));
        end
        @(negedge clk); abort = 1'b1; #1;
        check("t4_addr4", 32'(buf_addr), 3);
        @(negedge clk); abort = 1'b0; #1;
        check("t4_busy", 32'(busy), 0);
        check("t4_fcclr", 32'(fc_clr), 1);
        check("t4_fv", 32'(feat_valid), 0);
        check("t4_rd_en", 32'(buf_rd_en), 0);
        check("t4_done", 32'(done), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check("t4_fv_after", 32'(feat_valid), 0);
            check("t4_done_after", 32'(done), 0);
            check("t4_fcclr_after", 32'(fc_clr), 0);
        end
        check("t4_err", 32'(err), 0);
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0; #1;
        check("t4_sa_busy", 32'(busy), 0);
        check("t4_sa_rd_en", 32'(buf_rd_en), 0);
        check("t4_sa_fcclr", 32'(fc_clr), 0);

        // 5) start and sum_valid during STREAM, start during DRAIN: all ignored
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        rd_cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            start = (c == 3);
            sum_valid = (c == 3);
            is_one = (c == 3);
            #1;
            if (buf_rd_en) rd_cnt++;
        end
        @(negedge clk); start = 1'b1; sum_valid = 1'b0; is_one = 1'b0; #1;
        check("t5_reads", 32'(rd_cnt), 8);
        check("t5_drain_busy", 32'(busy), 1);
        check("t5_drain_rd_en", 32'(buf_rd_en), 0);
        @(negedge clk); start = 1'b0; sum_valid = 1'b1; is_one = 1'b0;
        @(negedge clk); sum_valid = 1'b0; #1;
        check("t5_done", 32'(done), 1);
        check("t5_cnt", 32'(frame_cnt), 3);
        check("t5_res", 32'(result_is_one), 0);
        @(negedge clk); #1;
        check("t5_idle1", 32'(busy), 0);
        @(negedge clk); #1;
        check("t5_idle2", 32'(busy), 0);

        // 6) frame_cnt wrap, then reset in the middle of STREAM
        @(negedge clk);
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (7) @(negedge clk);
        @(negedge clk); sum_valid = 1'b1; is_one = 1'b1;
        @(negedge clk); sum_valid = 1'b0; is_one = 1'b0; #1;
        check("t6_done", 32'(done), 1);
        check("t6_wrap", 32'(frame_cnt), 0);
        check("t6_res", 32'(result_is_one), 1);
        @(negedge clk);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1; #1;
        check("t6_pre_rst_busy", 32'(busy), 1);
        @(negedge clk); #1;
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_rd_en", 32'(buf_rd_en), 0);
        check("t6_rst_addr", 32'(buf_addr), 0);
        check("t6_rst_fv", 32'(feat_valid), 0);
        check("t6_rst_data", 32'(feat_data), 0);
        check("t6_rst_done", 32'(done), 0);
        check("t6_rst_err", 32'(err), 0);
        check("t6_rst_fcclr", 32'(fc_clr), 0);
        check("t6_rst_res", 32'(result_is_one), 0);
        check("t6_rst_cnt", 32'(frame_cnt), 0);
        @(negedge clk); rst = 1'b0; #1;
        check("t6_post_done", 32'(done), 0);
        check("t6_post_fcclr", 32'(fc_clr), 0);
        @(negedge clk); #1;
        check("t6_post_busy", 32'(busy), 0);
        check("t6_post_done2", 32'(done), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
